// File: rtl/morse_word_tx.sv
// Keys one latched word of Morse slots onto a single registered output; busy covers every phase, done pulses once at the end.
// First phase is active one cycle after start; each phase lasts its length in ce ticks; start is ignored while busy.
module morse_word_tx #(
  parameter int MAX_CHARS   = 8,
  parameter int SYM_MAX     = 6,
  parameter int LEN_W       = 3,
  parameter int SLOT_W      = LEN_W + SYM_MAX,
  parameter int PULSE_CNT_W = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ce,
  input  logic [PULSE_CNT_W-1:0]        dit_time,
  input  logic [PULSE_CNT_W-1:0]        dah_time,
  input  logic [PULSE_CNT_W-1:0]        word_time,
  input  logic [SLOT_W*MAX_CHARS-1:0]   word,
  input  logic                          end_word,
  input  logic                          start,
  output logic                          signal,
  output logic                          busy,
  output logic                          done
);

  localparam int IDX_W = (MAX_CHARS > 1) ? $clog2(MAX_CHARS) : 1;
  localparam logic [LEN_W-1:0] SYM_MAX_L = LEN_W'(SYM_MAX);
  localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(MAX_CHARS - 1);
  localparam logic [PULSE_CNT_W-1:0] ONE = PULSE_CNT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_MARK, S_GAP, S_DONE} state_t;

  function automatic logic [LEN_W-1:0] f_len(input logic [SLOT_W*MAX_CHARS-1:0] w, input int k);
    logic [LEN_W-1:0] l;
    l = w[k*SLOT_W+SYM_MAX +: LEN_W];
    return (l > SYM_MAX_L) ? SYM_MAX_L : l;
  endfunction

  function automatic logic [SYM_MAX-1:0] f_pat(input logic [SLOT_W*MAX_CHARS-1:0] w, input int k);
    return w[k*SLOT_W +: SYM_MAX];
  endfunction

  function automatic logic f_bit(input logic [SYM_MAX-1:0] pat, input logic [LEN_W-1:0] idx);
    logic [SYM_MAX-1:0] t;
    t = pat >> idx;
    return t[0];
  endfunction

  function automatic logic [PULSE_CNT_W-1:0] f_ld(input logic [PULSE_CNT_W-1:0] x);
    return (x == '0) ? ONE : x;
  endfunction

  state_t                        r_state;
  logic [SLOT_W*MAX_CHARS-1:0]   r_word;
  logic                          r_end_word;
  logic [PULSE_CNT_W-1:0]        r_dit, r_dah, r_wt, r_cnt;
  logic [IDX_W-1:0]              r_slot;
  logic [LEN_W-1:0]              r_sym;
  logic                          r_lead;
  logic                          r_signal, r_busy, r_done;

  logic [LEN_W-1:0]       w_cur_len, w_nxt_len, w_sym_nxt, w_in_len0;
  logic [SYM_MAX-1:0]     w_cur_pat, w_nxt_pat, w_in_pat0;
  logic [IDX_W-1:0]       w_nxt_slot;
  logic                   w_last_slot, w_more_syms, w_more_chars;
  logic [PULSE_CNT_W-1:0] w_gap_len;

  assign w_last_slot  = (r_slot == LAST_SLOT);
  assign w_nxt_slot   = w_last_slot ? r_slot : r_slot + 1'b1;
  assign w_cur_len    = f_len(r_word, int'(r_slot));
  assign w_cur_pat    = f_pat(r_word, int'(r_slot));
  assign w_nxt_len    = f_len(r_word, int'(w_nxt_slot));
  assign w_nxt_pat    = f_pat(r_word, int'(w_nxt_slot));
  assign w_in_len0    = f_len(word, 0);
  assign w_in_pat0    = f_pat(word, 0);
  assign w_sym_nxt    = r_sym + 1'b1;
  assign w_more_syms  = (w_sym_nxt < w_cur_len);
  // An empty current slot terminates the word, whatever follows it.
  assign w_more_chars = (w_cur_len != '0) && !w_last_slot && (w_nxt_len != '0);
  assign w_gap_len    = w_more_syms  ? r_dit :
                        w_more_chars ? r_dah :
                        r_end_word   ? r_wt  : r_dah;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_word     <= '0;
      r_end_word <= 1'b0;
      r_dit      <= '0;
      r_dah      <= '0;
      r_wt       <= '0;
      r_cnt      <= '0;
      r_slot     <= '0;
      r_sym      <= '0;
      r_lead     <= 1'b0;
      r_signal   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_word     <= word;
            r_end_word <= end_word;
            r_dit      <= dit_time;
            r_dah      <= dah_time;
            r_wt       <= word_time;
            r_busy     <= 1'b1;
            r_slot     <= '0;
            r_sym      <= '0;
            if (w_in_len0 != '0) begin
              r_state  <= S_MARK;
              r_signal <= 1'b1;
              r_cnt    <= f_ld(w_in_pat0[0] ? dah_time : dit_time);
              r_lead   <= 1'b0;
            end else begin
              // Empty word: one lead-in tick, then the optional word gap.
              r_state  <= S_GAP;
              r_signal <= 1'b0;
              r_cnt    <= ONE;
              r_lead   <= 1'b1;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_MARK: begin
          if (ce) begin
            if (r_cnt == ONE) begin
              r_state  <= S_GAP;
              r_signal <= 1'b0;
              r_cnt    <= f_ld(w_gap_len);
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
        end
        S_GAP: begin
          if (ce) begin
            if (r_cnt != ONE) begin
              r_cnt <= r_cnt - 1'b1;
            end else if (r_lead && r_end_word) begin
              r_lead <= 1'b0;
              r_cnt  <= f_ld(r_wt);
            end else if (w_more_syms) begin
              r_sym    <= w_sym_nxt;
              r_state  <= S_MARK;
              r_signal <= 1'b1;
              r_cnt    <= f_ld(f_bit(w_cur_pat, w_sym_nxt) ? r_dah : r_dit);
            end else if (w_more_chars) begin
              r_slot   <= w_nxt_slot;
              r_sym    <= '0;
              r_state  <= S_MARK;
              r_signal <= 1'b1;
              r_cnt    <= f_ld(w_nxt_pat[0] ? r_dah : r_dit);
            end else begin
              r_lead  <= 1'b0;
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_cnt   <= '0;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign signal = r_signal;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule

// File: tb/tb_morse_word_tx.sv
// Drives directed and random words into morse_word_tx and compares every cycle with a phase-list reference model.
module tb_morse_word_tx;
  localparam int MC = 8, SM = 6, LW = 3, SW = 9, PW = 16, NMAX = 4096;

  logic clk = 1'b0;
  logic rst_n, ce, end_word, start;
  logic [PW-1:0] dit_time, dah_time, word_time;
  logic [SW*MC-1:0] word;
  logic signal, busy, done;

  int tests = 0, fails = 0;
  bit es[NMAX], eb[NMAX], ed[NMAX];
  bit os[NMAX], ob[NMAX], odn[NMAX];

  always #5 clk = ~clk;

  morse_word_tx #(.MAX_CHARS(MC), .SYM_MAX(SM), .LEN_W(LW), .SLOT_W(SW), .PULSE_CNT_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .dit_time(dit_time), .dah_time(dah_time),
    .word_time(word_time), .word(word), .end_word(end_word), .start(start),
    .signal(signal), .busy(busy), .done(done)
  );

  function automatic int ld(input int x);
    return (x == 0) ? 1 : x;
  endfunction

  function automatic logic [SW-1:0] mk(input int len, input int pat);
    logic [LW-1:0] l;
    logic [SM-1:0] p;
    l = LW'(len);
    p = SM'(pat);
    return {l, p};
  endfunction

  // Reference: list the keyed phases from the word, then lay them out on the ce timeline.
  task automatic model(input logic [SW*MC-1:0] w, input bit ew, input int dt, input int da,
                       input int wt, input int per, output int dcyc);
    int lv[$];
    int ln[$];
    int nch, l, c, t;
    for (int i = 0; i < NMAX; i++) begin es[i] = 0; eb[i] = 0; ed[i] = 0; end
    nch = 0;
    while (nch < MC && w[nch*SW+SM +: LW] != 0) nch++;
    if (nch == 0) begin
      lv.push_back(0); ln.push_back(1);
      if (ew) begin lv.push_back(0); ln.push_back(ld(wt)); end
    end
    for (int ch = 0; ch < nch; ch++) begin
      l = int'(w[ch*SW+SM +: LW]);
      if (l > SM) l = SM;
      for (int s = 0; s < l; s++) begin
        lv.push_back(1); ln.push_back(w[ch*SW+s] ? ld(da) : ld(dt));
        lv.push_back(0);
        if (s < l - 1)        ln.push_back(ld(dt));
        else if (ch < nch - 1) ln.push_back(ld(da));
        else                   ln.push_back(ew ? ld(wt) : ld(da));
      end
    end
    c = 1;
    foreach (lv[i]) begin
      t = 0;
      while (t < ln[i]) begin
        es[c] = (lv[i] != 0); eb[c] = 1;
        if (c % per == 0) t++;
        c++;
      end
    end
    ed[c] = 1;
    dcyc = c;
  endtask

  task automatic run_word(input string tag, input logic [SW*MC-1:0] w, input bit ew, input int dt,
                          input int da, input int wt, input int per, output int odc, output int dcyc);
    int ms, mb, md, fs, fb, fd;
    model(w, ew, dt, da, wt, per, dcyc);
    @(negedge clk);
    word = w; end_word = ew; dit_time = PW'(dt); dah_time = PW'(da); word_time = PW'(wt);
    start = 1'b1; ce = 1'b1;
    @(posedge clk);
    odc = -1;
    for (int k = 1; k <= dcyc + 2; k++) begin
      @(negedge clk);
      os[k] = signal; ob[k] = busy; odn[k] = done;
      if (done && odc < 0) odc = k;
      ce = ((k % per) == 0);
      start = 1'b0;
      // Scramble inputs and pulse start while busy: both must be ignored.
      if (k < dcyc) begin
        word = {$urandom, $urandom, $urandom};
        dit_time = PW'($urandom); dah_time = PW'($urandom); word_time = PW'($urandom);
        end_word = $urandom_range(0, 1);
        start = ($urandom_range(0, 7) == 0);
      end
    end
    ce = 1'b1;
    ms = 0; mb = 0; md = 0; fs = 0; fb = 0; fd = 0;
    for (int c = dcyc + 2; c >= 1; c--) begin
      if (os[c] != es[c])  begin ms++; fs = c; end
      if (ob[c] != eb[c])  begin mb++; fb = c; end
      if (odn[c] != ed[c]) begin md++; fd = c; end
    end
    tests++;
    assert (ms === 0) else begin fails++; $error("FAIL %s signal cycle %0d observed %0b expected %0b", tag, fs, os[fs], es[fs]); end
    tests++;
    assert (mb === 0) else begin fails++; $error("FAIL %s busy cycle %0d observed %0b expected %0b", tag, fb, ob[fb], eb[fb]); end
    tests++;
    assert (md === 0) else begin fails++; $error("FAIL %s done cycle %0d observed %0b expected %0b", tag, fd, odn[fd], ed[fd]); end
  endtask

  task automatic check_done_at(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin fails++; $error("FAIL %s done_cycle observed %0d expected %0d", tag, obs, exp); end
  endtask

  // Recover slots from the observed waveform by classifying run lengths.
  task automatic decode_check(input string tag, input logic [SW*MC-1:0] w, input int dt, input int da, input int dcyc);
    logic [SW*MC-1:0] dec;
    logic [SM-1:0] cp;
    int k, cl, run, thr;
    bit lvl;
    dec = '0; cp = '0; k = 0; cl = 0; run = 0; thr = (dt + da) / 2;
    lvl = os[1];
    for (int c = 1; c <= dcyc; c++) begin
      if (c == dcyc || os[c] != lvl) begin
        if (lvl) begin
          if (cl < SM) cp[cl] = (run > thr);
          cl++;
        end else if (run > thr) begin
          if (k < MC) dec[k*SW +: SW] = {LW'(cl), cp};
          k++; cl = 0; cp = '0;
        end
        lvl = os[c]; run = 0;
      end
      run++;
    end
    tests++;
    assert (dec === w) else begin fails++; $error("FAIL %s decoded observed %h expected %h", tag, dec, w); end
  endtask

  initial begin
    logic [SW*MC-1:0] w;
    logic [SW-1:0] abc[6];
    int odc, dcyc, n, nd;

    rst_n = 1'b0; ce = 1'b0; start = 1'b0; end_word = 1'b0; word = '0;
    dit_time = '0; dah_time = '0; word_time = '0;
    #12;
    tests++; assert (signal === 1'b0) else begin fails++; $error("FAIL reset_signal observed %b expected 0", signal); end
    tests++; assert (busy === 1'b0)   else begin fails++; $error("FAIL reset_busy observed %b expected 0", busy); end
    tests++; assert (done === 1'b0)   else begin fails++; $error("FAIL reset_done observed %b expected 0", done); end
    @(negedge clk); rst_n = 1'b1; ce = 1'b1;

    w = '0; w[0 +: SW] = mk(2, 2);
    run_word("A", w, 1, 2, 6, 14, 1, odc, dcyc);
    check_done_at("A", odc, 25);

    w = '0; w[0 +: SW] = mk(1, 0); w[SW +: SW] = mk(1, 1);
    run_word("ET", w, 0, 2, 6, 14, 1, odc, dcyc);
    check_done_at("ET", odc, 21);

    abc[0] = mk(2, 2); abc[1] = mk(4, 1); abc[2] = mk(4, 5);
    abc[3] = mk(3, 1); abc[4] = mk(1, 0); abc[5] = mk(4, 4);
    w = '0;
    for (int i = 0; i < 6; i++) w[i*SW +: SW] = abc[i];
    run_word("ABCDEF", w, 1, 10, 30, 70, 1, odc, dcyc);
    decode_check("ABCDEF", w, 10, 30, dcyc);
    for (int i = 0; i < 6; i++) begin
      w = '0; w[0 +: SW] = abc[i];
      run_word("ABCDEF_char", w, (i == 2 || i == 5), 10, 30, 70, 1, odc, dcyc);
    end

    w = '0; w[0 +: SW] = mk(1, 0);
    run_word("E_ce3", w, 1, 2, 6, 4, 3, odc, dcyc);
    check_done_at("E_ce3", odc, 19);

    w = '0;
    run_word("empty0", w, 0, 2, 6, 5, 1, odc, dcyc);
    check_done_at("empty0", odc, 2);
    run_word("empty1", w, 1, 2, 6, 5, 1, odc, dcyc);
    check_done_at("empty1", odc, 7);

    w = '0; w[0 +: SW] = mk(3, 0);
    run_word("S_dit0", w, 1, 0, 3, 2, 1, odc, dcyc);
    check_done_at("S_dit0", odc, 8);

    w = '0; w[0 +: SW] = mk(7, 6'b101101); w[SW +: SW] = mk(2, 1);
    run_word("clamp", w, 1, 1, 3, 5, 2, odc, dcyc);

    // Back-to-back: start in the done cycle is accepted.
    @(negedge clk);
    word = '0; word[0 +: SW] = mk(1, 0); end_word = 1'b0;
    dit_time = 1; dah_time = 1; word_time = 1; start = 1'b1; ce = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests++; assert ({done, busy} === 2'b10) else begin fails++; $error("FAIL b2b_done observed %b expected 10", {done, busy}); end
    word = '0; word[0 +: SW] = mk(1, 1); dah_time = 3; start = 1'b1;
    @(negedge clk); start = 1'b0;
    tests++; assert ({busy, signal} === 2'b11) else begin fails++; $error("FAIL b2b_restart observed %b expected 11", {busy, signal}); end
    nd = 0;
    repeat (12) begin @(negedge clk); if (done) nd++; end
    tests++; assert (nd === 1) else begin fails++; $error("FAIL b2b_second_done observed %0d expected 1", nd); end

    // Reset in the middle of a dah.
    @(negedge clk);
    word = '0; word[0 +: SW] = mk(1, 1); end_word = 1'b1;
    dit_time = 2; dah_time = 20; word_time = 4; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    tests++; assert (signal === 1'b1) else begin fails++; $error("FAIL mid_dah_signal observed %b expected 1", signal); end
    #2 rst_n = 1'b0;
    #1;
    tests++; assert ({signal, busy} === 2'b00) else begin fails++; $error("FAIL async_reset observed %b expected 00", {signal, busy}); end
    nd = 0;
    repeat (3) begin @(negedge clk); if (done) nd++; end
    tests++; assert (nd === 0) else begin fails++; $error("FAIL reset_no_done observed %0d expected 0", nd); end
    rst_n = 1'b1;

    w = '0; w[0 +: SW] = mk(2, 2);
    run_word("A_after_reset", w, 1, 2, 6, 14, 1, odc, dcyc);
    check_done_at("A_after_reset", odc, 25);

    for (int r = 0; r < 20; r++) begin
      w = {$urandom, $urandom, $urandom};
      n = $urandom_range(0, MC);
      for (int i = 0; i < n; i++) w[i*SW+SM +: LW] = LW'($urandom_range(1, 7));
      if (n < MC) w[n*SW+SM +: LW] = '0;
      run_word("random", w, $urandom_range(0, 1), $urandom_range(0, 4), $urandom_range(0, 6),
               $urandom_range(0, 8), $urandom_range(1, 3), odc, dcyc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
